// File: rtl/common_cells.sv
// Datapath primitives (register, one-hot AND-OR muxes) plus a top-level
// wrapper that exposes each cell and a counter built from a DFF and a Mux4.
module DFF #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= in;
  end

endmodule

module Mux2 #(
  parameter int n = 1
) (
  input  logic [n-1:0] a1,
  input  logic [n-1:0] a0,
  input  logic [1:0]   s,
  output logic [n-1:0] b
);

  // AND-OR select: no priority, overlapping selects OR their legs together
  assign b = ({n{s[1]}} & a1) | ({n{s[0]}} & a0);

endmodule

module Mux4 #(
  parameter int n = 1
) (
  input  logic [n-1:0] a3,
  input  logic [n-1:0] a2,
  input  logic [n-1:0] a1,
  input  logic [n-1:0] a0,
  input  logic [3:0]   s,
  output logic [n-1:0] b
);

  assign b = ({n{s[3]}} & a3) | ({n{s[2]}} & a2) |
             ({n{s[1]}} & a1) | ({n{s[0]}} & a0);

endmodule

module common_cells #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_dff_in,
  output logic [DATA_W-1:0] o_dff_out,
  input  logic [DATA_W-1:0] i_m2_a1,
  input  logic [DATA_W-1:0] i_m2_a0,
  input  logic [1:0]        i_m2_s,
  output logic [DATA_W-1:0] o_m2_b,
  input  logic              i_mode_a3,
  input  logic              i_mode_a2,
  input  logic              i_mode_a1,
  input  logic              i_mode_a0,
  input  logic [3:0]        i_mode_s,
  output logic              o_mode_b,
  input  logic [DATA_W-1:0] i_m4_a3,
  input  logic [DATA_W-1:0] i_m4_a2,
  input  logic [DATA_W-1:0] i_m4_a1,
  input  logic [DATA_W-1:0] i_m4_a0,
  input  logic [3:0]        i_m4_s,
  output logic [DATA_W-1:0] o_m4_b,
  input  logic [DATA_W-1:0] i_cnt_load,
  input  logic [3:0]        i_cnt_s,
  output logic [DATA_W-1:0] o_cnt_out
);

  logic [DATA_W-1:0] w_cnt_out;
  logic [DATA_W-1:0] w_cnt_dec;
  logic [DATA_W-1:0] w_cnt_next;

  DFF #(.n(DATA_W)) u_dff (
    .clk (clk),
    .rst (rst),
    .in  (i_dff_in),
    .out (o_dff_out)
  );

  Mux2 #(.n(DATA_W)) u_mux2 (
    .a1 (i_m2_a1),
    .a0 (i_m2_a0),
    .s  (i_m2_s),
    .b  (o_m2_b)
  );

  Mux4 #(.n(1)) u_mode (
    .a3 (i_mode_a3),
    .a2 (i_mode_a2),
    .a1 (i_mode_a1),
    .a0 (i_mode_a0),
    .s  (i_mode_s),
    .b  (o_mode_b)
  );

  Mux4 #(.n(DATA_W)) u_mux4 (
    .a3 (i_m4_a3),
    .a2 (i_m4_a2),
    .a1 (i_m4_a1),
    .a0 (i_m4_a0),
    .s  (i_m4_s),
    .b  (o_m4_b)
  );

  // Counter: select order {hold, load, step, clear} -> {out, load, out-1, 0}
  assign w_cnt_dec = w_cnt_out - DATA_W'(1);

  Mux4 #(.n(DATA_W)) u_cnt_mux (
    .a3 (w_cnt_out),
    .a2 (i_cnt_load),
    .a1 (w_cnt_dec),
    .a0 ('0),
    .s  (i_cnt_s),
    .b  (w_cnt_next)
  );

  DFF #(.n(DATA_W)) u_cnt_reg (
    .clk (clk),
    .rst (rst),
    .in  (w_cnt_next),
    .out (w_cnt_out)
  );

  assign o_cnt_out = w_cnt_out;

endmodule

// File: tb/tb_common_cells.sv
// Bench for common_cells: directed cases then randomized traffic against a
// behavioural model of the register, muxes and counter.
module tb_common_cells;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] dff_in, dff_out;
  logic [8:0] m2_a1, m2_a0, m2_b;
  logic [1:0] m2_s;
  logic       mode_a3, mode_a2, mode_a1, mode_a0, mode_b;
  logic [3:0] mode_s;
  logic [8:0] m4_a3, m4_a2, m4_a1, m4_a0, m4_b;
  logic [3:0] m4_s;
  logic [8:0] cnt_load, cnt_out;
  logic [3:0] cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  common_cells #(.DATA_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_dff_in   (dff_in),
    .o_dff_out  (dff_out),
    .i_m2_a1    (m2_a1),
    .i_m2_a0    (m2_a0),
    .i_m2_s     (m2_s),
    .o_m2_b     (m2_b),
    .i_mode_a3  (mode_a3),
    .i_mode_a2  (mode_a2),
    .i_mode_a1  (mode_a1),
    .i_mode_a0  (mode_a0),
    .i_mode_s   (mode_s),
    .o_mode_b   (mode_b),
    .i_m4_a3    (m4_a3),
    .i_m4_a2    (m4_a2),
    .i_m4_a1    (m4_a1),
    .i_m4_a0    (m4_a0),
    .i_m4_s     (m4_s),
    .o_m4_b     (m4_b),
    .i_cnt_load (cnt_load),
    .i_cnt_s    (cnt_s),
    .o_cnt_out  (cnt_out)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every selected leg contributes, unselected legs contribute nothing
  function automatic logic [8:0] sel_ref(input logic [3:0] s, input logic [8:0] l3,
                                         input logic [8:0] l2, input logic [8:0] l1,
                                         input logic [8:0] l0);
    logic [8:0] legs [4];
    logic [8:0] r;
    legs[0] = l0; legs[1] = l1; legs[2] = l2; legs[3] = l3;
    r = 9'd0;
    for (int k = 0; k < 4; k++)
      if (s[k]) r = r | legs[k];
    return r;
  endfunction

  logic [8:0] m_dff, m_cnt, m_dec, exp_dff, exp_cnt;

  initial begin
    rst = 1'b1; dff_in = '0;
    m2_a1 = '0; m2_a0 = '0; m2_s = '0;
    mode_a3 = 0; mode_a2 = 0; mode_a1 = 0; mode_a0 = 0; mode_s = '0;
    m4_a3 = '0; m4_a2 = '0; m4_a1 = '0; m4_a0 = '0; m4_s = '0;
    cnt_load = '0; cnt_s = '0;

    tick();
    check("dff_reset", dff_out, 9'd0);
    check("cnt_reset", cnt_out, 9'd0);

    rst = 1'b0; dff_in = 9'd300;
    #1 check("dff_before_edge", dff_out, 9'd0);
    tick();
    check("dff_load_300", dff_out, 9'd300);

    dff_in = 9'h1FF; rst = 1'b1;
    tick();
    check("dff_rst_over_in", dff_out, 9'd0);

    rst = 1'b0; dff_in = 9'd300;
    tick();
    check("dff_reload_300", dff_out, 9'd300);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1 check("dff_midcycle_rst", dff_out, 9'd300);
    tick();
    check("dff_after_pulse", dff_out, 9'd300);

    m2_a1 = 9'd5; m2_a0 = 9'd7;
    m2_s = 2'b10; #1 check("mux2_s10", m2_b, 9'd5);
    m2_s = 2'b01; #1 check("mux2_s01", m2_b, 9'd7);
    m2_s = 2'b00; #1 check("mux2_s00", m2_b, 9'd0);
    m2_s = 2'b11; #1 check("mux2_s11", m2_b, 9'd7);

    mode_a3 = 0; mode_a2 = 0; mode_a1 = 1; mode_a0 = 0;
    mode_s = 4'b0010; #1 check("mode_0010", {8'd0, mode_b}, 9'd1);
    mode_s = 4'b0001; #1 check("mode_0001", {8'd0, mode_b}, 9'd0);
    mode_s = 4'b0100; #1 check("mode_0100", {8'd0, mode_b}, 9'd0);
    mode_s = 4'b1000; #1 check("mode_1000", {8'd0, mode_b}, 9'd0);
    mode_s = 4'b0000; #1 check("mode_0000", {8'd0, mode_b}, 9'd0);

    m4_a3 = 9'd40; m4_a2 = 9'd100; m4_a1 = 9'd39; m4_a0 = 9'd0;
    m4_s = 4'b1000; #1 check("mux4_hold", m4_b, 9'd40);
    m4_s = 4'b0100; #1 check("mux4_load", m4_b, 9'd100);
    m4_s = 4'b0010; #1 check("mux4_step", m4_b, 9'd39);
    m4_s = 4'b0001; #1 check("mux4_clear", m4_b, 9'd0);
    m4_s = 4'b0110; #1 check("mux4_or", m4_b, 9'd103);

    rst = 1'b1; tick(); rst = 1'b0;
    check("cnt_rst", cnt_out, 9'd0);
    cnt_load = 9'd10; cnt_s = 4'b0100; tick();
    check("cnt_load10", cnt_out, 9'd10);
    cnt_s = 4'b0010;
    tick(); check("cnt_step9", cnt_out, 9'd9);
    tick(); check("cnt_step8", cnt_out, 9'd8);
    tick(); check("cnt_step7", cnt_out, 9'd7);
    cnt_s = 4'b1000; tick(); check("cnt_hold7", cnt_out, 9'd7);
    tick(); check("cnt_hold7b", cnt_out, 9'd7);
    cnt_s = 4'b0001; tick(); check("cnt_clear", cnt_out, 9'd0);
    cnt_s = 4'b0010; tick(); check("cnt_wrap", cnt_out, 9'd511);

    rst = 1'b1; tick();
    m_dff = 9'd0; m_cnt = 9'd0;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      dff_in = 9'($urandom);
      m2_a1 = 9'($urandom); m2_a0 = 9'($urandom); m2_s = 2'($urandom);
      {mode_a3, mode_a2, mode_a1, mode_a0} = 4'($urandom);
      mode_s = 4'($urandom);
      m4_a3 = 9'($urandom); m4_a2 = 9'($urandom);
      m4_a1 = 9'($urandom); m4_a0 = 9'($urandom);
      m4_s = 4'($urandom);
      cnt_load = 9'($urandom);
      if ($urandom_range(0, 3) != 0) cnt_s = 4'b0001 << $urandom_range(0, 3);
      else                           cnt_s = 4'($urandom);
      #1;
      check("rnd_mux2", m2_b, sel_ref({2'b00, m2_s}, 9'd0, 9'd0, m2_a1, m2_a0));
      check("rnd_mode", {8'd0, mode_b},
            sel_ref(mode_s, {8'd0, mode_a3}, {8'd0, mode_a2}, {8'd0, mode_a1}, {8'd0, mode_a0}));
      check("rnd_mux4", m4_b, sel_ref(m4_s, m4_a3, m4_a2, m4_a1, m4_a0));
      m_dec = m_cnt - 9'd1;
      exp_dff = rst ? 9'd0 : dff_in;
      exp_cnt = rst ? 9'd0 : sel_ref(cnt_s, m_cnt, cnt_load, m_dec, 9'd0);
      tick();
      m_dff = exp_dff; m_cnt = exp_cnt;
      check("rnd_dff", dff_out, m_dff);
      check("rnd_cnt", cnt_out, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
